// File: rtl/ps2_key_decoder.sv
// ----------------------------------------------------------------------------
// ps2_key_decoder
//   Receives raw PS/2 keyboard frames, decodes scan-code set 2 and reports the
//   last released letter key (A..Z = 0..25, Enter = 31) with a one-cycle
//   release strobe for the downstream player FSM.
//
// Ports
//   clk          in   system clock, sole clock domain
//   reset        in   synchronous, active-high reset
//   ps2_clk      in   raw PS/2 clock from keyboard (asynchronous)
//   ps2_data     in   raw PS/2 data from keyboard (asynchronous)
//   keystroke    out  [4:0] last released key code
//   keyReleased  out  one-cycle strobe, cycle after keystroke updates
//   key_held     out  high while a mapped key is down
//   frame_err    out  one-cycle strobe on bad start/parity/stop or timeout
// ----------------------------------------------------------------------------
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [4:0] keystroke,
    output logic       keyReleased,
    output logic       key_held,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BREAK     = 2'd1,
        ST_EXT       = 2'd2,
        ST_EXT_BREAK = 2'd3
    } state_t;

    // Odd parity over data+parity bit: XOR of all nine bits must be 1.
    function automatic logic odd_parity_ok(input logic [8:0] v);
        return ^v;
    endfunction

    // Scan-code set 2 to letter code; bit 5 flags a mapped key.
    function automatic logic [5:0] map_key(input logic [7:0] b);
        logic [5:0] r;
        case (b)
            8'h1C: r = {1'b1, 5'd0};
            8'h32: r = {1'b1, 5'd1};
            8'h21: r = {1'b1, 5'd2};
            8'h23: r = {1'b1, 5'd3};
            8'h24: r = {1'b1, 5'd4};
            8'h2B: r = {1'b1, 5'd5};
            8'h34: r = {1'b1, 5'd6};
            8'h33: r = {1'b1, 5'd7};
            8'h43: r = {1'b1, 5'd8};
            8'h3B: r = {1'b1, 5'd9};
            8'h42: r = {1'b1, 5'd10};
            8'h4B: r = {1'b1, 5'd11};
            8'h3A: r = {1'b1, 5'd12};
            8'h31: r = {1'b1, 5'd13};
            8'h44: r = {1'b1, 5'd14};
            8'h4D: r = {1'b1, 5'd15};
            8'h15: r = {1'b1, 5'd16};
            8'h2D: r = {1'b1, 5'd17};
            8'h1B: r = {1'b1, 5'd18};
            8'h2C: r = {1'b1, 5'd19};
            8'h3C: r = {1'b1, 5'd20};
            8'h2A: r = {1'b1, 5'd21};
            8'h1D: r = {1'b1, 5'd22};
            8'h22: r = {1'b1, 5'd23};
            8'h35: r = {1'b1, 5'd24};
            8'h1A: r = {1'b1, 5'd25};
            8'h5A: r = {1'b1, 5'd31};
            default: r = 6'd0;
        endcase
        return r;
    endfunction

    // Receiver state
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [10:0]            frame_q, frame_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic                   byte_valid_q, byte_valid_d;
    logic [7:0]             byte_q, byte_d;
    logic                   frame_err_q, frame_err_d;

    // Decoder state
    state_t                 state_q, state_d;
    logic [4:0]             keystroke_q, keystroke_d;
    logic                   key_held_q, key_held_d;
    logic                   rel_pend_q, rel_pend_d;
    logic                   key_released_q, key_released_d;

    logic                   clk_s, data_s, fall_s;
    logic [5:0]             map_s;

    assign clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];
    assign fall_s = clk_prev_q & ~clk_s;
    assign map_s  = map_key(byte_q);

    // Receiver next-state: synchroniser shift, bit capture, frame checks, timeout
    always_comb begin
        clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        data_sync_d  = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_prev_d   = clk_s;
        bit_cnt_d    = bit_cnt_q;
        frame_d      = frame_q;
        timer_d      = timer_q;
        byte_valid_d = 1'b0;
        byte_d       = byte_q;
        frame_err_d  = 1'b0;
        if (fall_s) begin
            timer_d = {TW{1'b0}};
            // Bits shift in from the top; after 10 shifts frame_q[1] is the
            // start bit, [9:2] the data byte and [10] the parity bit.
            frame_d = {data_s, frame_q[10:1]};
            if (bit_cnt_q == 4'd0) begin
                // Reject a bad start bit immediately so we resync on the next edge.
                if (data_s) begin
                    frame_err_d = 1'b1;
                end else begin
                    bit_cnt_d = 4'd1;
                end
            end else if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = 4'd0;
                if (data_s && odd_parity_ok(frame_q[10:2])) begin
                    byte_valid_d = 1'b1;
                    byte_d       = frame_q[9:2];
                end else begin
                    frame_err_d = 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                bit_cnt_d   = 4'd0;
                timer_d     = {TW{1'b0}};
                frame_err_d = 1'b1;
            end else begin
                timer_d = timer_q + {{(TW-1){1'b0}}, 1'b1};
            end
        end else begin
            timer_d = {TW{1'b0}};
        end
    end

    // Decode FSM next-state and output registers
    always_comb begin
        state_d        = state_q;
        keystroke_d    = keystroke_q;
        key_held_d     = key_held_q;
        rel_pend_d     = 1'b0;
        key_released_d = rel_pend_q;   // strobe trails the keystroke update by one cycle
        if (byte_valid_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_q == 8'hF0) begin
                        state_d = ST_BREAK;
                    end else if (byte_q == 8'hE0) begin
                        state_d = ST_EXT;
                    end else if (map_s[5]) begin
                        key_held_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BREAK: begin
                    state_d = ST_IDLE;
                    if (map_s[5]) begin
                        keystroke_d = map_s[4:0];
                        key_held_d  = 1'b0;
                        rel_pend_d  = 1'b1;
                    end else begin
                        keystroke_d = keystroke_q;
                    end
                end
                ST_EXT: begin
                    if (byte_q == 8'hF0) begin
                        state_d = ST_EXT_BREAK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_EXT_BREAK: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State registers with synchronous reset; PS/2 lines idle high
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q     <= {SYNC_STAGES{1'b1}};
            data_sync_q    <= {SYNC_STAGES{1'b1}};
            clk_prev_q     <= 1'b1;
            bit_cnt_q      <= 4'd0;
            frame_q        <= 11'd0;
            timer_q        <= {TW{1'b0}};
            byte_valid_q   <= 1'b0;
            byte_q         <= 8'd0;
            frame_err_q    <= 1'b0;
            state_q        <= ST_IDLE;
            keystroke_q    <= 5'd0;
            key_held_q     <= 1'b0;
            rel_pend_q     <= 1'b0;
            key_released_q <= 1'b0;
        end else begin
            clk_sync_q     <= clk_sync_d;
            data_sync_q    <= data_sync_d;
            clk_prev_q     <= clk_prev_d;
            bit_cnt_q      <= bit_cnt_d;
            frame_q        <= frame_d;
            timer_q        <= timer_d;
            byte_valid_q   <= byte_valid_d;
            byte_q         <= byte_d;
            frame_err_q    <= frame_err_d;
            state_q        <= state_d;
            keystroke_q    <= keystroke_d;
            key_held_q     <= key_held_d;
            rel_pend_q     <= rel_pend_d;
            key_released_q <= key_released_d;
        end
    end

    assign keystroke   = keystroke_q;
    assign keyReleased = key_released_q;
    assign key_held    = key_held_q;
    assign frame_err   = frame_err_q;

endmodule
